query_sweep: RTL and testbench



---
 rtl/query_sweep.sv | 183 ++++++++++++++++++
 tb/tb_query_sweep.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/query_sweep.sv
// rtl/query_sweep.sv - candidate pair enumerator driving a combinational Query block
//
// Purpose: walks every (p1, p2) atom pair (p2 inner, p1 outer, ascending),
// presents it on q_p1/q_p2, samples q_valid in the same cycle and streams
// each satisfying pair out over a valid/ready handshake while counting hits.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         begin a sweep (IDLE only) / return to IDLE from anywhere
//   busy, done           sweep in progress / one-cycle completion pulse
//   q_p1, q_p2, q_valid  candidate pair to Query and its combinational verdict
//   sol_valid/ready      solution handshake, sol_p1/sol_p2 the solution pair
//   sol_count            saturating number of solutions in current/last sweep
//
// Configuration macro: QUERY_SWEEP_SKIP_DIAG_EN - never drive pairs with p1==p2.

module query_sweep #(
    parameter int ATOM_W    = 3,
    parameter int NUM_ATOMS = 6,
    parameter int CNT_W     = 2*ATOM_W+1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ATOM_W-1:0] q_p1,
    output logic [ATOM_W-1:0] q_p2,
    input  logic              q_valid,
    output logic              sol_valid,
    input  logic              sol_ready,
    output logic [ATOM_W-1:0] sol_p1,
    output logic [ATOM_W-1:0] sol_p2,
    output logic [CNT_W-1:0]  sol_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam int PW = ATOM_W + 1;

`ifdef QUERY_SWEEP_SKIP_DIAG_EN
    localparam bit SKIP_DIAG = 1'b1;
`else
    localparam bit SKIP_DIAG = 1'b0;
`endif

    // With the diagonal skipped the final pair is (N-1, N-2); N==1 has no pairs.
    localparam int LAST_P2_I = SKIP_DIAG ? ((NUM_ATOMS > 1) ? NUM_ATOMS - 2 : 0)
                                         : NUM_ATOMS - 1;
    localparam logic [ATOM_W-1:0] LAST_P1    = ATOM_W'(NUM_ATOMS - 1);
    localparam logic [ATOM_W-1:0] LAST_P2    = ATOM_W'(LAST_P2_I);
    localparam logic [ATOM_W-1:0] FIRST_P2   = SKIP_DIAG ? ATOM_W'(1) : '0;
    localparam bit                NO_PAIRS   = SKIP_DIAG && (NUM_ATOMS == 1);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               sol_valid_q;
    logic [ATOM_W-1:0]  p1_q;
    logic [ATOM_W-1:0]  p2_q;
    logic [ATOM_W-1:0]  sol_p1_q;
    logic [ATOM_W-1:0]  sol_p2_q;
    logic [CNT_W-1:0]   sol_count_q;

    logic [PW-1:0]      inc_p2;
    logic [ATOM_W-1:0]  p1_d;
    logic [ATOM_W-1:0]  p2_d;
    logic               is_last;
    logic [CNT_W-1:0]   sol_count_inc;

    // Successor of the current pair. p2 is widened by one bit so the row
    // wrap is detectable even when NUM_ATOMS == 2**ATOM_W. Overflow of p1
    // only happens past the last pair, which is never taken.
    always_comb begin
        inc_p2 = {1'b0, p2_q} + 1'b1;
        if (inc_p2 == PW'(NUM_ATOMS)) begin
            p1_d = p1_q + 1'b1;
            p2_d = '0;
        end else begin
            p1_d = p1_q;
            p2_d = inc_p2[ATOM_W-1:0];
        end
        // A row wrap lands on p2=0 with p1>=1, so only same-row steps can
        // hit the diagonal; one extra step clears it.
        if (SKIP_DIAG && (p2_d == p1_d)) begin
            p2_d = p2_d + 1'b1;
        end
    end

    assign is_last       = (p1_q == LAST_P1) && (p2_q == LAST_P2);
    assign sol_count_inc = (&sol_count_q) ? sol_count_q : sol_count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sol_valid_q <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            sol_p1_q    <= '0;
            sol_p2_q    <= '0;
            sol_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                sol_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            sol_count_q <= '0;
                            p1_q        <= '0;
                            p2_q        <= FIRST_P2;
                            if (NO_PAIRS) begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_SCAN;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_SCAN: begin
                        if (q_valid) begin
                            sol_p1_q    <= p1_q;
                            sol_p2_q    <= p2_q;
                            sol_count_q <= sol_count_inc;
                            sol_valid_q <= 1'b1;
                            state_q     <= S_EMIT;
                        end else if (is_last) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            p1_q <= p1_d;
                            p2_q <= p2_d;
                        end
                    end
                    S_EMIT: begin
                        // Candidate stays frozen until the solution is taken.
                        if (sol_ready) begin
                            sol_valid_q <= 1'b0;
                            if (is_last) begin
                                state_q <= S_FIN;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_SCAN;
                                p1_q    <= p1_d;
                                p2_q    <= p2_d;
                            end
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign q_p1      = p1_q;
    assign q_p2      = p2_q;
    assign sol_valid = sol_valid_q;
    assign sol_p1    = sol_p1_q;
    assign sol_p2    = sol_p2_q;
    assign sol_count = sol_count_q;

endmodule

// File: tb/tb_query_sweep.sv
// tb/tb_query_sweep.sv - self-checking bench for query_sweep against a pair-list model

module tb_query_sweep;

    localparam int AW = 3;
    localparam int N  = 6;
    localparam int CW = 2*AW+1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done;
    logic [AW-1:0] q_p1, q_p2;
    logic          q_valid;
    logic          sol_valid;
    logic          sol_ready = 1'b1;
    logic [AW-1:0] sol_p1, sol_p2;
    logic [CW-1:0] sol_count;

    logic [63:0]   tbl = '0;   // Query truth table indexed by {p1,p2}

    assign q_valid = tbl[{q_p1, q_p2}];

    query_sweep #(.ATOM_W(AW), .NUM_ATOMS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .q_p1(q_p1), .q_p2(q_p2), .q_valid(q_valid),
        .sol_valid(sol_valid), .sol_ready(sol_ready),
        .sol_p1(sol_p1), .sol_p2(sol_p2), .sol_count(sol_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Observation of the DUT, sampled with pre-edge values.
    logic       mon_clr = 1'b0;
    logic [5:0] got[$];
    int         busy_cyc = 0;
    int         done_cnt = 0;
    int         valid_cyc = 0;

    always @(posedge clk) begin
        if (mon_clr) begin
            got.delete();
            busy_cyc  <= 0;
            done_cnt  <= 0;
            valid_cyc <= 0;
        end else begin
            if (sol_valid && sol_ready) got.push_back({sol_p1, sol_p2});
            if (busy)      busy_cyc  <= busy_cyc + 1;
            if (done)      done_cnt  <= done_cnt + 1;
            if (sol_valid) valid_cyc <= valid_cyc + 1;
        end
    end

    // Reference: the ordered list of driven pairs, the solutions among them,
    // and (for sol_ready tied high) the candidate seen in each busy cycle.
    logic [5:0] exp_pairs[$];
    logic [5:0] exp_sols[$];
    logic [5:0] exp_cyc[$];

    task automatic build_model();
        exp_pairs.delete();
        exp_sols.delete();
        exp_cyc.delete();
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
                logic [5:0] pr;
                pr = {3'(a), 3'(b)};
`ifdef QUERY_SWEEP_SKIP_DIAG_EN
                if (a == b) continue;
`endif
                exp_pairs.push_back(pr);
                exp_cyc.push_back(pr);
                if (tbl[pr]) begin
                    exp_sols.push_back(pr);
                    exp_cyc.push_back(pr);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_sweep();
        build_model();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            if (rnd) sol_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        sol_ready = 1'b1;
        check("sweep_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input bit tied);
        int m;
        check({tag, "_nsol"}, 32'(got.size()), 32'(exp_sols.size()));
        m = (got.size() < exp_sols.size()) ? got.size() : exp_sols.size();
        for (int i = 0; i < m; i++) check({tag, "_sol"}, 32'(got[i]), 32'(exp_sols[i]));
        check({tag, "_count"}, 32'(sol_count), 32'(exp_sols.size()));
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (tied) check({tag, "_busy"}, 32'(busy_cyc), 32'(exp_pairs.size() + exp_sols.size()));
        else      check({tag, "_busy"}, 32'(busy_cyc), 32'(exp_pairs.size() + valid_cyc));
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(sol_valid), 32'd0);
        check("rst_q", 32'({q_p1, q_p2}), 32'd0);
        check("rst_sol", 32'({sol_p1, sol_p2}), 32'd0);
        check("rst_count", 32'(sol_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // friends.pl: solutions (0,2) and (2,0), ready tied high
        tbl = '0;
        tbl[{3'd0, 3'd2}] = 1'b1;
        tbl[{3'd2, 3'd0}] = 1'b1;
        begin_sweep();
        check("fr_first_q", 32'({q_p1, q_p2}), 32'(exp_pairs[0]));
        check("fr_busy_on", 32'(busy), 32'd1);
        wait_done(1'b0);
        check_result("friends", 1'b1);

        // Same model, consumer stalls 5 cycles at the first solution
        sol_ready = 1'b0;
        begin_sweep();
        n = 0;
        while (!sol_valid && n < 200) begin @(negedge clk); n++; end
        check("stall_reach", 32'(sol_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) sol_ready = 1'b1;
            check("stall_valid", 32'(sol_valid), 32'd1);
            check("stall_sol", 32'({sol_p1, sol_p2}), 32'({3'd0, 3'd2}));
            check("stall_q", 32'({q_p1, q_p2}), 32'({3'd0, 3'd2}));
            if (i < 5) @(negedge clk);
        end
        wait_done(1'b0);
        check("stall_busy", 32'(busy_cyc), 32'(exp_pairs.size() + exp_sols.size() + 5));
        check("stall_nsol", 32'(got.size()), 32'(exp_sols.size()));
        check("stall_count", 32'(sol_count), 32'(exp_sols.size()));

        // Every pair is a solution
        tbl = '1;
        begin_sweep();
        wait_done(1'b0);
        check_result("all", 1'b1);

        // Abort during the EMIT of the first solution, then restart
        tbl = '0;
        tbl[{3'd0, 3'd2}] = 1'b1;
        tbl[{3'd2, 3'd0}] = 1'b1;
        sol_ready = 1'b0;
        begin_sweep();
        n = 0;
        while (!sol_valid && n < 200) begin @(negedge clk); n++; end
        check("abort_reach", 32'(sol_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(sol_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(sol_count), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_done", 32'(done_cnt), 32'd0);
        sol_ready = 1'b1;
        tbl = '1;
        begin_sweep();
        check("restart_count", 32'(sol_count), 32'd0);
        check("restart_q", 32'({q_p1, q_p2}), 32'(exp_pairs[0]));
        wait_done(1'b0);
        check_result("restart", 1'b1);

        // Start pulses during busy are ignored; reset mid-SCAN is asynchronous
        tbl = '0;
        tbl[{3'd0, 3'd1}] = 1'b1;
        tbl[{3'd0, 3'd3}] = 1'b1;
        begin_sweep();
        check("seq_q0", 32'({q_p1, q_p2}), 32'(exp_cyc[0]));
        for (int i = 1; i < 10; i++) begin
            start = 1'($urandom);
            @(negedge clk);
            check("seq_q", 32'({q_p1, q_p2}), 32'(exp_cyc[i]));
        end
        start = 1'b0;
        check("pre_rst_count", 32'(sol_count), 32'(exp_sols.size()));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(sol_valid), 32'd0);
        check("arst_q", 32'({q_p1, q_p2}), 32'd0);
        check("arst_sol", 32'({sol_p1, sol_p2}), 32'd0);
        check("arst_count", 32'(sol_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random truth tables with a randomly stalling consumer
        for (int r = 0; r < 5; r++) begin
            tbl = {$urandom, $urandom};
            begin_sweep();
            wait_done(1'b1);
            check_result("rand", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
